rock_hit_detector: RTL and testbench
====================================

Name: rock_hit_detector

Overview:
Companion to the rock motion block. It consumes the rock's current position plus the plane and bullet positions, and detects overlaps once per move tick. It drives the collision and planehit levels back into the rock motion block. Those levels are held until the rock is seen to respawn, and the block also maintains score, lives and game-over for the game top level.

Parameters:
ROCK_W, 32, rock width in pixels
ROCK_H, 32, rock height in pixels
PLANE_W, 32, plane width
PLANE_H, 32, plane height
BULLET_W, 4, bullet width
BULLET_H, 8, bullet height
LIVES, 3, lives loaded at reset/restart (1..15)
SCORE_W, 10, score counter width
HOLD_MAX, 1023, max cycles a hit level is held before forced release
INVULN_TICKS, 64, move ticks of plane invulnerability (INVULN_EN only)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset (0 = reset)
move  input  1  frame move tick, same pulse that drives the rock motion block
restart  input  1  one-cycle pulse; leaves OVER state
rock_x  input  11  rock top-left x (from rock motion block ox)
rock_y  input  11  rock top-left y (from rock motion block oy)
plane_x  input  11  plane top-left x
plane_y  input  11  plane top-left y
bullet_x  input  11  bullet top-left x
bullet_y  input  11  bullet top-left y
bullet_valid  input  1  bullet on screen
collision  output  1  bullet-rock hit level, to rock motion block
planehit  output  1  plane-rock hit level, to rock motion block
bullet_kill  output  1  one-cycle pulse: retire the bullet
score  output  SCORE_W  rocks destroyed, saturating
lives  output  4  remaining lives
game_over  output  1  high in OVER state

Behaviour:
- Reset (rst=0, async):
  - state=ARM.
  - collision, planehit, bullet_kill, game_over = 0.
  - score=0, lives=LIVES.
  - Latched positions = 0, hold counter = 0.
- Overlap test is AABB on 12-bit zero-extended values to avoid wrap: ax < bx+bw and bx < ax+aw, and the same in y. Touching edges are not a hit.
- ARM:
  - When move=1, latch rock, plane and bullet positions plus bullet_valid → EVAL.
  - No other action.
- EVAL (exactly one cycle after the move sample):
  - Bullet hit (latched valid and bullet/rock overlap):
    - collision←1, bullet_kill pulses 1 cycle.
    - score+1, saturating at all-ones.
    - → HOLD.
  - Else plane hit:
    - planehit←1, lives−1.
    - If the new lives value is 0 → OVER, else → HOLD.
  - Bullet and plane hit on the same tick: bullet wins. Only collision is raised and lives are unchanged.
  - No hit → ARM.
- HOLD:
  - The hit level stays high until the rock respawns, because the rock motion block samples the level only on its own move tick.
  - Release when rock_y < latched rock_y. The respawn y is always < 128, while a live rock is only moving down.
  - Forced release after HOLD_MAX cycles in HOLD.
  - On release: collision=planehit=0, hold counter cleared → ARM.
  - move ticks arriving during HOLD are ignored.
- OVER:
  - game_over=1, and planehit stays asserted so the rock respawns.
  - All detection is disabled.
  - restart=1 → lives=LIVES, score=0, planehit=0, game_over=0 → ARM.
  - restart is ignored in every other state.
- Reset mid-HOLD or mid-OVER: outputs go to reset values immediately, with no stale pulse.
- Latency: move sampled at edge N; hit outputs are visible after edge N+1.

Optional Feature:
INVULN_EN
- Defined: after any planehit, plane overlaps are ignored for the next INVULN_TICKS move ticks. Bullet hits are still checked during that window. The invulnerability counter resets to 0 on reset and on restart.
- Undefined: no counter exists and every plane overlap in EVAL counts.

Test Plan:
1. Reset with default LIVES → score=0, lives=3, all hit outputs 0. Set rst=0 mid-HOLD → collision falls to 0 asynchronously.
2. Bullet hit: rock (100,200), bullet (110,210) valid, plane far away, move pulse → collision=1 and bullet_kill=1 one cycle after the sample, score=1. Then drop rock_y to 40 → collision=0 next cycle, state ARM.
3. Edge touch: rock (100,200), plane (132,200), move → no hit, back to ARM. Then plane (131,200), move → planehit=1, lives=2.
4. Simultaneous: bullet and plane both overlapping the rock, move → collision=1, planehit=0, lives unchanged, score+1.
5. Three plane hits with respawns between them → lives 2,1,0; after the third, game_over=1 and planehit held. A further move does nothing. restart pulse → lives=3, score=0, game_over=0.
6. HOLD timeout: hit, then hold rock_y constant → release after exactly HOLD_MAX cycles. With INVULN_EN defined: a second plane overlap within 64 ticks is ignored, and one at tick 65 is counted.

Source files
------------

// File: rtl/rock_hit_detector.sv
// rock_hit_detector
//   Detects bullet/rock and plane/rock overlaps once per move tick and drives
//   the collision / planehit levels back into the rock motion block. A hit level
//   is held until the rock is seen to respawn (its y jumps back up) or until
//   HOLD_MAX cycles have passed. The block also keeps the score, the remaining
//   lives and the game-over flag.
//
//   Optional build macro INVULN_EN: after a plane hit, plane overlaps are
//   ignored for the next INVULN_TICKS move ticks. Bullet hits are still checked.
//
// Ports
//   clk           system clock
//   rst           asynchronous active-low reset (0 = reset)
//   move          frame move tick (same pulse as the rock motion block)
//   restart       one-cycle pulse, leaves the OVER state
//   rock_x/y      rock top-left position (11 bit)
//   plane_x/y     plane top-left position (11 bit)
//   bullet_x/y    bullet top-left position (11 bit)
//   bullet_valid  bullet on screen
//   collision     bullet-rock hit level
//   planehit      plane-rock hit level
//   bullet_kill   one-cycle pulse that retires the bullet
//   score         rocks destroyed, saturating
//   lives         remaining lives
//   game_over     high in the OVER state
module rock_hit_detector #(
  parameter int ROCK_W       = 32,
  parameter int ROCK_H       = 32,
  parameter int PLANE_W      = 32,
  parameter int PLANE_H      = 32,
  parameter int BULLET_W     = 4,
  parameter int BULLET_H     = 8,
  parameter int LIVES        = 3,
  parameter int SCORE_W      = 10,
  parameter int HOLD_MAX     = 1023,
  parameter int INVULN_TICKS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move,
  input  logic               restart,
  input  logic [10:0]        rock_x,
  input  logic [10:0]        rock_y,
  input  logic [10:0]        plane_x,
  input  logic [10:0]        plane_y,
  input  logic [10:0]        bullet_x,
  input  logic [10:0]        bullet_y,
  input  logic               bullet_valid,
  output logic               collision,
  output logic               planehit,
  output logic               bullet_kill,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic               game_over
);

  localparam int HCNT_W = $clog2(HOLD_MAX + 1);

  if (LIVES < 1 || LIVES > 15 || HOLD_MAX < 1 || INVULN_TICKS < 1) begin : g_param_check
    $error("rock_hit_detector: parameter out of range");
  end

  typedef enum logic [1:0] {ARM, EVAL, HOLD, OVER} state_t;

  // AABB test on 12-bit zero-extended operands so x+w never wraps.
  // Strict compares: boxes that only touch at an edge do not overlap.
  function automatic logic overlap(input logic [10:0] ax, input logic [10:0] ay,
                                   input logic [11:0] aw, input logic [11:0] ah,
                                   input logic [10:0] bx, input logic [10:0] by,
                                   input logic [11:0] bw, input logic [11:0] bh);
    logic [11:0] ax12, ay12, bx12, by12;
    ax12 = {1'b0, ax};
    ay12 = {1'b0, ay};
    bx12 = {1'b0, bx};
    by12 = {1'b0, by};
    return (ax12 < bx12 + bw) && (bx12 < ax12 + aw) &&
           (ay12 < by12 + bh) && (by12 < ay12 + ah);
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t               state_q, state_d;
  logic [10:0]          rock_x_p1, rock_y_p1, plane_x_p1, plane_y_p1;
  logic [10:0]          bullet_x_p1, bullet_y_p1;
  logic                 vld_p1;
  logic [10:0]          rock_x_d, rock_y_d, plane_x_d, plane_y_d;
  logic [10:0]          bullet_x_d, bullet_y_d;
  logic                 vld_d;
  logic [HCNT_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic                 collision_d, planehit_d, bullet_kill_d, game_over_d;
  logic [SCORE_W-1:0]   score_d;
  logic [3:0]           lives_d;
  logic                 bullet_hit, plane_hit;
`ifdef INVULN_EN
  logic [$clog2(INVULN_TICKS+1)-1:0] inv_cnt_q, inv_cnt_d;
  logic                 inv_p1, inv_d;   // window state as seen at the move sample
`endif

  assign bullet_hit = vld_p1 &&
                      overlap(bullet_x_p1, bullet_y_p1, 12'(BULLET_W), 12'(BULLET_H),
                              rock_x_p1, rock_y_p1, 12'(ROCK_W), 12'(ROCK_H));
`ifdef INVULN_EN
  assign plane_hit  = !inv_p1 &&
                      overlap(plane_x_p1, plane_y_p1, 12'(PLANE_W), 12'(PLANE_H),
                              rock_x_p1, rock_y_p1, 12'(ROCK_W), 12'(ROCK_H));
`else
  assign plane_hit  = overlap(plane_x_p1, plane_y_p1, 12'(PLANE_W), 12'(PLANE_H),
                              rock_x_p1, rock_y_p1, 12'(ROCK_W), 12'(ROCK_H));
`endif

  always_comb begin
    state_d       = state_q;
    rock_x_d      = rock_x_p1;
    rock_y_d      = rock_y_p1;
    plane_x_d     = plane_x_p1;
    plane_y_d     = plane_y_p1;
    bullet_x_d    = bullet_x_p1;
    bullet_y_d    = bullet_y_p1;
    vld_d         = vld_p1;
    hold_cnt_d    = hold_cnt_q;
    collision_d   = collision;
    planehit_d    = planehit;
    bullet_kill_d = 1'b0;
    game_over_d   = game_over;
    score_d       = score;
    lives_d       = lives;
`ifdef INVULN_EN
    inv_d         = inv_p1;
    inv_cnt_d     = inv_cnt_q;
    // The window counts every move tick, whatever the state.
    if (move && inv_cnt_q != '0) inv_cnt_d = inv_cnt_q - 1'b1;
`endif

    case (state_q)
      ARM: begin
        if (move) begin
          rock_x_d   = rock_x;
          rock_y_d   = rock_y;
          plane_x_d  = plane_x;
          plane_y_d  = plane_y;
          bullet_x_d = bullet_x;
          bullet_y_d = bullet_y;
          vld_d      = bullet_valid;
`ifdef INVULN_EN
          inv_d      = (inv_cnt_q != '0);
`endif
          state_d    = EVAL;
        end
      end
      EVAL: begin
        // A bullet hit takes priority; the plane is spared on that tick.
        if (bullet_hit) begin
          collision_d   = 1'b1;
          bullet_kill_d = 1'b1;
          score_d       = sat_inc(score);
          state_d       = HOLD;
        end else if (plane_hit) begin
          planehit_d = 1'b1;
          lives_d    = lives - 4'd1;
`ifdef INVULN_EN
          inv_cnt_d  = ($bits(inv_cnt_q))'(INVULN_TICKS);
`endif
          if (lives == 4'd1) begin
            game_over_d = 1'b1;
            state_d     = OVER;
          end else begin
            state_d     = HOLD;
          end
        end else begin
          state_d = ARM;
        end
      end
      HOLD: begin
        // A live rock only moves down, so a smaller y means it respawned.
        if (rock_y < rock_y_p1 || hold_cnt_q == HCNT_W'(HOLD_MAX - 1)) begin
          collision_d = 1'b0;
          planehit_d  = 1'b0;
          hold_cnt_d  = '0;
          state_d     = ARM;
        end else begin
          hold_cnt_d  = hold_cnt_q + 1'b1;
        end
      end
      OVER: begin
        // planehit stays high here so the rock keeps respawning.
        if (restart) begin
          lives_d     = 4'(LIVES);
          score_d     = '0;
          planehit_d  = 1'b0;
          game_over_d = 1'b0;
`ifdef INVULN_EN
          inv_cnt_d   = '0;
`endif
          state_d     = ARM;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARM;
      rock_x_p1   <= '0;
      rock_y_p1   <= '0;
      plane_x_p1  <= '0;
      plane_y_p1  <= '0;
      bullet_x_p1 <= '0;
      bullet_y_p1 <= '0;
      vld_p1      <= 1'b0;
      hold_cnt_q  <= '0;
      collision   <= 1'b0;
      planehit    <= 1'b0;
      bullet_kill <= 1'b0;
      game_over   <= 1'b0;
      score       <= '0;
      lives       <= 4'(LIVES);
`ifdef INVULN_EN
      inv_p1      <= 1'b0;
      inv_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rock_x_p1   <= rock_x_d;
      rock_y_p1   <= rock_y_d;
      plane_x_p1  <= plane_x_d;
      plane_y_p1  <= plane_y_d;
      bullet_x_p1 <= bullet_x_d;
      bullet_y_p1 <= bullet_y_d;
      vld_p1      <= vld_d;
      hold_cnt_q  <= hold_cnt_d;
      collision   <= collision_d;
      planehit    <= planehit_d;
      bullet_kill <= bullet_kill_d;
      game_over   <= game_over_d;
      score       <= score_d;
      lives       <= lives_d;
`ifdef INVULN_EN
      inv_p1      <= inv_d;
      inv_cnt_q   <= inv_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_rock_hit_detector.sv
// Directed bench for rock_hit_detector (default build, INVULN_EN undefined).
module tb_rock_hit_detector;
  localparam int HOLD_MAX = 1023;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        move = 1'b0;
  logic        restart = 1'b0;
  logic [10:0] rock_x = '0, rock_y = '0, plane_x = '0, plane_y = '0;
  logic [10:0] bullet_x = '0, bullet_y = '0;
  logic        bullet_valid = 1'b0;
  logic        collision, planehit, bullet_kill, game_over;
  logic [9:0]  score;
  logic [3:0]  lives;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rock_hit_detector dut (
    .clk(clk), .rst(rst), .move(move), .restart(restart),
    .rock_x(rock_x), .rock_y(rock_y), .plane_x(plane_x), .plane_y(plane_y),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_valid(bullet_valid),
    .collision(collision), .planehit(planehit), .bullet_kill(bullet_kill),
    .score(score), .lives(lives), .game_over(game_over)
  );

  // Move pulse driven between negedges; returns at the negedge after the
  // evaluation edge, when hit outputs are visible.
  task automatic do_move();
    @(negedge clk) move = 1'b1;
    @(negedge clk) move = 1'b0;
    @(negedge clk);
  endtask

  // Rock jumps back to the top, then returns to y=200 for the next test.
  task automatic respawn();
    rock_y = 11'd40;
    @(negedge clk);
    rock_y = 11'd200;
  endtask

  task automatic set_pos(input int rx, input int ry, input int px, input int py,
                         input int bx, input int by, input logic bv);
    rock_x = 11'(rx); rock_y = 11'(ry);
    plane_x = 11'(px); plane_y = 11'(py);
    bullet_x = 11'(bx); bullet_y = 11'(by);
    bullet_valid = bv;
  endtask

  task automatic apply_reset();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (score !== 10'd0) begin errors++; $display("FAIL reset_score got=%0d exp=0", score); end
    checks++; if (lives !== 4'd3) begin errors++; $display("FAIL reset_lives got=%0d exp=3", lives); end
    checks++; if ({collision, planehit, bullet_kill, game_over} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {collision, planehit, bullet_kill, game_over}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bullet_hit();
    set_pos(100, 200, 600, 600, 110, 210, 1'b1);
    do_move();
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL bh_collision got=%b exp=1", collision); end
    checks++; if (bullet_kill !== 1'b1) begin errors++; $display("FAIL bh_kill got=%b exp=1", bullet_kill); end
    checks++; if (score !== 10'd1) begin errors++; $display("FAIL bh_score got=%0d exp=1", score); end
    checks++; if (planehit !== 1'b0) begin errors++; $display("FAIL bh_planehit got=%b exp=0", planehit); end
    @(negedge clk);
    checks++; if (bullet_kill !== 1'b0) begin errors++; $display("FAIL bh_kill_pulse got=%b exp=0", bullet_kill); end
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL bh_held got=%b exp=1", collision); end
    respawn();
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL bh_release got=%b exp=0", collision); end
    bullet_valid = 1'b0;
    // Back in ARM: a fresh non-overlapping tick produces no hit.
    do_move();
    checks++; if ({collision, planehit} !== 2'b00) begin
      errors++; $display("FAIL bh_arm got=%b exp=00", {collision, planehit}); end
  endtask

  task automatic test_edge_touch();
    set_pos(100, 200, 132, 200, 0, 0, 1'b0);
    do_move();
    checks++; if (planehit !== 1'b0) begin errors++; $display("FAIL touch_planehit got=%b exp=0", planehit); end
    checks++; if (lives !== 4'd3) begin errors++; $display("FAIL touch_lives got=%0d exp=3", lives); end
    @(negedge clk) plane_x = 11'd131;
    do_move();
    checks++; if (planehit !== 1'b1) begin errors++; $display("FAIL overlap_planehit got=%b exp=1", planehit); end
    checks++; if (lives !== 4'd2) begin errors++; $display("FAIL overlap_lives got=%0d exp=2", lives); end
    respawn();
    checks++; if (planehit !== 1'b0) begin errors++; $display("FAIL overlap_release got=%b exp=0", planehit); end
  endtask

  task automatic test_simultaneous();
    set_pos(100, 200, 110, 210, 110, 210, 1'b1);
    do_move();
    checks++; if ({collision, planehit} !== 2'b10) begin
      errors++; $display("FAIL simul_levels got=%b exp=10", {collision, planehit}); end
    checks++; if (lives !== 4'd2) begin errors++; $display("FAIL simul_lives got=%0d exp=2", lives); end
    checks++; if (score !== 10'd2) begin errors++; $display("FAIL simul_score got=%0d exp=2", score); end
    respawn();
    bullet_valid = 1'b0;
  endtask

  task automatic test_game_over();
    apply_reset();
    // One bullet hit so the restart has a non-zero score to clear.
    set_pos(100, 200, 600, 600, 110, 210, 1'b1);
    do_move();
    respawn();
    set_pos(100, 200, 120, 220, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_move();
      checks++; if (lives !== 4'(2 - i)) begin
        errors++; $display("FAIL go_lives%0d got=%0d exp=%0d", i, lives, 2 - i); end
      if (i < 2) respawn();
    end
    checks++; if ({game_over, planehit} !== 2'b11) begin
      errors++; $display("FAIL go_flags got=%b exp=11", {game_over, planehit}); end
    respawn();
    checks++; if (planehit !== 1'b1) begin errors++; $display("FAIL go_planehit_held got=%b exp=1", planehit); end
    do_move();
    checks++; if ({game_over, planehit, lives} !== {2'b11, 4'd0}) begin
      errors++; $display("FAIL go_ignore_move got=%b/%0d exp=11/0", {game_over, planehit}, lives); end
    checks++; if (score !== 10'd1) begin errors++; $display("FAIL go_score got=%0d exp=1", score); end
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    checks++; if (lives !== 4'd3) begin errors++; $display("FAIL restart_lives got=%0d exp=3", lives); end
    checks++; if (score !== 10'd0) begin errors++; $display("FAIL restart_score got=%0d exp=0", score); end
    checks++; if ({game_over, planehit} !== 2'b00) begin
      errors++; $display("FAIL restart_flags got=%b exp=00", {game_over, planehit}); end
    plane_x = 11'd600;
  endtask

  task automatic test_hold_timeout();
    set_pos(100, 200, 600, 600, 110, 210, 1'b1);
    do_move();
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL to_start got=%b exp=1", collision); end
    // A move with the plane overlapping must be ignored during HOLD.
    @(negedge clk) begin plane_x = 11'd110; plane_y = 11'd210; move = 1'b1; end
    @(negedge clk) move = 1'b0;
    repeat (HOLD_MAX - 3) @(negedge clk);
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL to_before got=%b exp=1", collision); end
    checks++; if ({planehit, lives} !== {1'b0, 4'd3}) begin
      errors++; $display("FAIL to_move_ignored got=%b/%0d exp=0/3", planehit, lives); end
    @(negedge clk);
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL to_release got=%b exp=0", collision); end
    plane_x = 11'd600;
  endtask

  task automatic test_reset_mid_hold();
    set_pos(100, 200, 600, 600, 110, 210, 1'b1);
    do_move();
    checks++; if (collision !== 1'b1) begin errors++; $display("FAIL rmh_pre got=%b exp=1", collision); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({collision, bullet_kill} !== 2'b00) begin
      errors++; $display("FAIL rmh_async got=%b exp=00", {collision, bullet_kill}); end
    checks++; if (score !== 10'd0) begin errors++; $display("FAIL rmh_score got=%0d exp=0", score); end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    checks++; if (collision !== 1'b0) begin errors++; $display("FAIL rmh_after got=%b exp=0", collision); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_bullet_hit();
    test_edge_touch();
    test_simultaneous();
    test_game_over();
    test_hold_timeout();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
